// File: rtl/eq_band_scheduler_if.sv
// Sample-side handshake and shared MAC datapath bus of the equaliser band scheduler.
// Latency: none, signal bundle only.
// Backpressure: sample_ready gates sample_valid; the MAC side has no backpressure.
interface eq_band_scheduler_if #(
  parameter int NUM_BANDS = 3,
  parameter int TAPS      = 31,
  parameter int BAND_W    = $clog2(NUM_BANDS),
  parameter int TAP_W     = $clog2(TAPS)
);
  logic                   sample_valid;
  logic                   sample_ready;
  logic [23:0]            audio_in;
  logic [NUM_BANDS*8-1:0] band_gain;
  logic                   shift_en;
  logic [23:0]            shift_data;
  logic [BAND_W-1:0]      mac_band;
  logic [TAP_W-1:0]       mac_tap;
  logic                   mac_en;
  logic                   mac_clr;
  logic [40:0]            acc_in;
  logic [23:0]            audio_out;
  logic                   out_valid;

  // Scheduler side.
  modport master (
    input  sample_valid, audio_in, band_gain, acc_in,
    output sample_ready, shift_en, shift_data, mac_band, mac_tap, mac_en, mac_clr,
           audio_out, out_valid
  );

  // Audio source / MAC engine side.
  modport slave (
    output sample_valid, audio_in, band_gain, acc_in,
    input  sample_ready, shift_en, shift_data, mac_band, mac_tap, mac_en, mac_clr,
           audio_out, out_valid
  );
endinterface

// File: rtl/eq_band_scheduler.sv
// Time-shares one external MAC FIR across NUM_BANDS bands, applies per-band gain, mixes, saturates.
// Latency: accept -> out_valid in 2 + NUM_BANDS*(TAPS+MAC_LAT+1) cycles (plus frozen cycles).
// Backpressure: sample_ready only in IDLE with enable high; samples offered otherwise are dropped and flag overrun.
// Optional build macro EQ_SKIP_MUTED_EN: bands with zero latched gain are skipped entirely.
module eq_band_scheduler #(
  parameter int NUM_BANDS = 3,
  parameter int TAPS      = 31,
  parameter int MAC_LAT   = 2,
  parameter int BAND_W    = $clog2(NUM_BANDS),
  parameter int TAP_W     = $clog2(TAPS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic ovr_clr,
  output logic busy,
  output logic overrun,
  eq_band_scheduler_if.master bus
);

  typedef enum logic [2:0] {IDLE, SHIFT, MAC, WAIT, ACC, OUT} state_t;

  localparam logic [BAND_W:0] NO_BAND = (BAND_W+1)'(NUM_BANDS);

  state_t                 state, state_n;
  logic [23:0]            shift_data;
  logic [NUM_BANDS*8-1:0] gain_q;
  logic signed [27:0]     mix, mix_nxt;
  logic [BAND_W-1:0]      band;
  logic [TAP_W-1:0]       tap;
  logic [2:0]             wait_cnt;
  logic [23:0]            audio_out;
  logic [NUM_BANDS-1:0]   band_on;
  logic [BAND_W:0]        first_band, next_band;
  logic signed [23:0]     band_res;
  logic [7:0]             gain_sel;
  logic signed [32:0]     prod;
  logic [23:0]            sat;
  logic                   accept;
  logic                   unused_acc_lo;

  assign accept            = bus.sample_valid && bus.sample_ready;
  assign bus.sample_ready  = enable && (state == IDLE);
  assign bus.shift_en      = enable && (state == SHIFT);
  assign bus.mac_en        = enable && (state == MAC);
  assign bus.mac_clr       = bus.mac_en && (tap == '0);
  assign bus.out_valid     = enable && (state == OUT);
  assign bus.shift_data    = shift_data;
  assign bus.mac_band      = band;
  assign bus.mac_tap       = tap;
  assign bus.audio_out     = audio_out;
  assign busy              = (state != IDLE);
  assign unused_acc_lo     = ^bus.acc_in[16:0];

  // Which bands take part in this sample.
  always_comb begin
    band_on = '1;
`ifdef EQ_SKIP_MUTED_EN
    for (int i = 0; i < NUM_BANDS; i++) begin
      band_on[i] = (gain_q[i*8 +: 8] != 8'd0);
    end
`endif
  end

  // First active band, and the next active band after the current one (NO_BAND if none).
  always_comb begin
    first_band = NO_BAND;
    next_band  = NO_BAND;
    for (int i = NUM_BANDS-1; i >= 0; i--) begin
      if (band_on[i]) first_band = (BAND_W+1)'(i);
      if (band_on[i] && (i > int'(band))) next_band = (BAND_W+1)'(i);
    end
  end

  // Gain-scaled band contribution, next mix value and its saturated 24-bit form.
  always_comb begin
    band_res = bus.acc_in[40:17];
    gain_sel = gain_q[int'(band)*8 +: 8];
    prod     = band_res * $signed({1'b0, gain_sel});
    mix_nxt  = mix + 28'(prod >>> 7);
    if (mix_nxt > 28'sd8388607)       sat = 24'h7FFFFF;
    else if (mix_nxt < -28'sd8388608) sat = 24'h800000;
    else                              sat = mix_nxt[23:0];
  end

  // Next-state logic; a low enable holds the current state.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (accept) state_n = SHIFT;
      SHIFT: state_n = (first_band == NO_BAND) ? OUT : MAC;
      MAC:   if (tap == TAP_W'(TAPS-1)) state_n = (MAC_LAT == 0) ? ACC : WAIT;
      WAIT:  if (wait_cnt == 3'(MAC_LAT-1)) state_n = ACC;
      ACC:   state_n = (next_band == NO_BAND) ? OUT : MAC;
      OUT:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (!enable) state_n = state;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Sample/gain latch, band/tap walk, mix accumulation and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_data <= '0;
      gain_q     <= '0;
      mix        <= '0;
      band       <= '0;
      tap        <= '0;
      wait_cnt   <= '0;
      audio_out  <= '0;
    end else if (enable) begin
      case (state)
        IDLE: if (bus.sample_valid) begin
          shift_data <= bus.audio_in;
          gain_q     <= bus.band_gain;
        end
        SHIFT: begin
          mix  <= '0;
          band <= first_band[BAND_W-1:0];
          tap  <= '0;
          if (first_band == NO_BAND) audio_out <= '0;
        end
        MAC: begin
          wait_cnt <= '0;
          if (tap == TAP_W'(TAPS-1)) tap <= '0;
          else                       tap <= tap + 1'b1;
        end
        WAIT: wait_cnt <= wait_cnt + 1'b1;
        ACC: begin
          mix <= mix_nxt;
          if (next_band == NO_BAND) audio_out <= sat;
          else                      band <= next_band[BAND_W-1:0];
        end
        default: ;
      endcase
    end
  end

  // Sticky overrun: a sample offered while not ready sets it, and setting beats clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   overrun <= 1'b0;
    else if (bus.sample_valid && !bus.sample_ready) overrun <= 1'b1;
    else if (ovr_clr)                             overrun <= 1'b0;
  end

endmodule

// File: tb/tb_eq_band_scheduler.sv
// Bench for eq_band_scheduler: external delay line + MAC model, behavioural output reference.
// Latency: reference predicts the out_valid cycle from accept time, active band count and frozen cycles.
// Backpressure: reference tracks readiness and the sticky overrun flag.
module tb_eq_band_scheduler;
  localparam int NB      = 3;
  localparam int TAPS    = 31;
  localparam int MAC_LAT = 2;
  localparam int BLK     = TAPS + MAC_LAT + 1;
  localparam longint COEF = (64'sd1 <<< 17) / NB;

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, ovr_clr = 1'b0;
  logic busy, overrun;
  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;

  eq_band_scheduler_if #(.NUM_BANDS(NB), .TAPS(TAPS)) bus();

  eq_band_scheduler #(.NUM_BANDS(NB), .TAPS(TAPS), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ovr_clr(ovr_clr),
    .busy(busy), .overrun(overrun), .bus(bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- external delay line and MAC engine ----------------
  logic              clr_req = 1'b0;
  logic              force_acc = 1'b0;
  logic [40:0]       force_val = '0;
  logic signed [23:0] dl [TAPS];
  logic [40:0]       mac_acc = '0;

  initial for (int i = 0; i < TAPS; i++) dl[i] = '0;

  always @(posedge clk) begin
    if (clr_req) begin
      for (int i = 0; i < TAPS; i++) dl[i] <= '0;
    end else if (bus.shift_en) begin
      for (int i = 1; i < TAPS; i++) dl[i] <= dl[i-1];
      dl[0] <= $signed(bus.shift_data);
    end
    if (bus.mac_en)
      mac_acc <= bus.mac_clr ? 41'(COEF * longint'(dl[bus.mac_tap]))
                             : mac_acc + 41'(COEF * longint'(dl[bus.mac_tap]));
  end
  assign bus.acc_in = force_acc ? force_val : mac_acc;

  // ---------------- behavioural reference ----------------
  longint hist [TAPS];
  bit     pending = 0, ovr_m = 0;
  int     acc_cyc = 0, exp_cyc = 0;
  longint exp_out = 0, last_out = 0;
  int     obs_cnt = 0, obs_off = -1, n_en = 0, n_clr = 0, n_band_not1 = 0;
  longint obs_val = 0;

  function automatic bit band_active(input logic [NB*8-1:0] g, input int b);
`ifdef EQ_SKIP_MUTED_EN
    return g[b*8 +: 8] != 8'd0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int lat(input logic [NB*8-1:0] g);
    int n = 0;
    for (int b = 0; b < NB; b++) if (band_active(g, b)) n++;
    return 2 + n * BLK;
  endfunction

  function automatic longint ref_out(input logic [NB*8-1:0] g);
    longint mix = 0, acc, res;
    for (int b = 0; b < NB; b++) begin
      if (band_active(g, b)) begin
        if (force_acc) acc = longint'($signed(force_val));
        else begin
          acc = 0;
          for (int t = 0; t < TAPS; t++) acc += COEF * hist[t];
        end
        res = acc >>> 17;
        mix += (res * longint'(g[b*8 +: 8])) >>> 7;
      end
    end
    if (mix > 8388607)  mix = 8388607;
    if (mix < -8388608) mix = -8388608;
    return mix;
  endfunction

  initial for (int i = 0; i < TAPS; i++) hist[i] = 0;

  always @(negedge clk) begin
    bit rdy_m, exp_v;
    if (!rst_n) begin
      pending  = 0;
      last_out = 0;
      ovr_m    = 0;
    end else begin
      if (clr_req) begin
        for (int t = 0; t < TAPS; t++) hist[t] = 0;
        obs_cnt = 0; obs_off = -1; obs_val = 0; n_en = 0; n_clr = 0; n_band_not1 = 0;
      end
      rdy_m = enable && !pending;
      if (pending && !enable) exp_cyc++;
      exp_v = pending && (cyc == exp_cyc);
      chk("sample_ready", longint'(bus.sample_ready), longint'(rdy_m));
      chk("busy", longint'(busy), longint'(pending));
      chk("out_valid", longint'(bus.out_valid), longint'(exp_v));
      if (!enable)
        chk("frozen_strobes", longint'({bus.mac_en, bus.shift_en, bus.out_valid}), 0);
      if (bus.out_valid) begin
        obs_cnt++;
        obs_off = cyc - acc_cyc;
        obs_val = longint'($signed(bus.audio_out));
      end
      if (exp_v) begin
        chk("audio_out", longint'($signed(bus.audio_out)), exp_out);
        last_out = exp_out;
        pending  = 0;
      end else if (!(pending && !enable)) begin
        chk("audio_out_hold", longint'($signed(bus.audio_out)), last_out);
      end
      chk("overrun", longint'(overrun), longint'(ovr_m));
      if (bus.mac_en) n_en++;
      if (bus.mac_clr) n_clr++;
      if (bus.mac_en && bus.mac_band != 2'd1) n_band_not1++;
      if (bus.sample_valid && !rdy_m) ovr_m = 1;
      else if (ovr_clr)               ovr_m = 0;
      if (bus.sample_valid && rdy_m) begin
        for (int t = TAPS-1; t > 0; t--) hist[t] = hist[t-1];
        hist[0] = longint'($signed(bus.audio_in));
        pending = 1;
        acc_cyc = cyc;
        exp_cyc = cyc + lat(bus.band_gain);
        exp_out = ref_out(bus.band_gain);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_all();
    clr_req = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 clr_req = 1'b0;
  endtask

  task automatic send(input logic [23:0] s, input logic [NB*8-1:0] g);
    @(posedge clk);
    #1 bus.sample_valid = 1'b1; bus.audio_in = s; bus.band_gain = g;
    @(posedge clk);
    #1 bus.sample_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!pending && !busy) return;
    end
    chk("done_timeout", 0, 1);
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_strobes"}, longint'({bus.out_valid, bus.shift_en, bus.mac_en, bus.mac_clr, busy, overrun}), 0);
    chk({nm, "_audio_out"}, longint'(bus.audio_out), 0);
    chk({nm, "_idx"}, longint'({bus.mac_band, bus.mac_tap}), 0);
  endtask

  localparam logic [NB*8-1:0] G_UNITY = {NB{8'd128}};
  localparam logic [NB*8-1:0] G_MAX   = {NB{8'd255}};
  localparam logic [NB*8-1:0] G_MID   = {8'd0, 8'd128, 8'd0};

  initial begin
    bus.sample_valid = 1'b0;
    bus.audio_in     = '0;
    bus.band_gain    = '0;
    #3 chk_zero_outputs("reset");
    chk("reset_ready", longint'(bus.sample_ready), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; enable = 1'b1;
    clear_all();

    // Impulse at unity gain; band_gain changes after accept must not matter.
    send(24'd1000000, G_UNITY);
    bus.band_gain = 24'h010203;
    wait_done();
    chk("imp_latency", obs_off, 104);
    chk("imp_value", obs_val, 999984);
    chk("imp_mac_clr", n_clr, 3);
    chk("imp_mac_en", n_en, 93);
    chk("imp_strobes", obs_cnt, 1);

    // Only the middle band has gain.
    clear_all();
    send(24'd1000000, G_MID);
    wait_done();
    chk("mid_value", obs_val, 333328);
`ifdef EQ_SKIP_MUTED_EN
    chk("mid_latency", obs_off, 36);
    chk("mid_mac_en", n_en, 31);
    chk("mid_band_only1", n_band_not1, 0);
`else
    chk("mid_latency", obs_off, 104);
    chk("mid_mac_en", n_en, 93);
`endif

    // All bands muted.
    clear_all();
    send(24'd1000000, '0);
    wait_done();
    chk("mute_value", obs_val, 0);
`ifdef EQ_SKIP_MUTED_EN
    chk("mute_latency", obs_off, 2);
    chk("mute_mac_en", n_en, 0);
`else
    chk("mute_latency", obs_off, 104);
`endif

    // Saturation at both extremes.
    clear_all();
    force_acc = 1'b1;
    force_val = 41'h0FF_FFFF_FFFF;
    send(24'd0, G_MAX);
    wait_done();
    chk("sat_pos", obs_val, 8388607);
    clear_all();
    force_val = 41'h100_0000_0000;
    send(24'd0, G_MAX);
    wait_done();
    chk("sat_neg", obs_val, -8388608);
    force_acc = 1'b0;

    // Overrun: second sample at T+10 dropped; set beats clear.
    clear_all();
    send(24'd1000000, G_UNITY);
    repeat (9) @(posedge clk);
    #1 bus.sample_valid = 1'b1; bus.audio_in = 24'd555;
    @(posedge clk);
    #1 bus.sample_valid = 1'b0;
    @(negedge clk);
    chk("ovr_set", longint'(overrun), 1);
    @(posedge clk);
    #1 bus.sample_valid = 1'b1; ovr_clr = 1'b1;
    @(posedge clk);
    #1 bus.sample_valid = 1'b0; ovr_clr = 1'b0;
    @(negedge clk);
    chk("ovr_set_wins", longint'(overrun), 1);
    wait_done();
    chk("ovr_strobes", obs_cnt, 1);
    chk("ovr_value", obs_val, 999984);
    @(posedge clk);
    #1 ovr_clr = 1'b1;
    @(posedge clk);
    #1 ovr_clr = 1'b0;
    @(negedge clk);
    chk("ovr_cleared", longint'(overrun), 0);

    // Enable freeze for 20 cycles from T+40.
    clear_all();
    send(24'd1000000, G_UNITY);
    repeat (39) @(posedge clk);
    #1 enable = 1'b0;
    repeat (20) @(posedge clk);
    #1 enable = 1'b1;
    wait_done();
    chk("frz_latency", obs_off, 124);
    chk("frz_value", obs_val, 999984);
    chk("frz_mac_en", n_en, 93);

    // Reset in the middle of a sample.
    clear_all();
    send(24'd1000000, G_UNITY);
    repeat (49) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_zero_outputs("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", longint'(bus.sample_ready), 1);
    repeat (150) @(posedge clk);
    chk("midrst_no_strobe", obs_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
